// File: rtl/me_frame_loader.sv
// Loads a reference block and a search window into local byte stores, kicks the
// motion estimator, serves its reads and hands its result (or a watchdog abort) downstream.
module me_frame_loader #(
  parameter int RMEM_MAX = 256,
  parameter int SMEM_MAX = 1024,
  parameter int TIMEOUT  = 4095
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       start,
  input  logic [7:0] AddressR,
  input  logic [9:0] AddressS1,
  input  logic [9:0] AddressS2,
  output logic [7:0] R,
  output logic [7:0] S1,
  output logic [7:0] S2,
  input  logic       completed,
  input  logic [3:0] motionX,
  input  logic [3:0] motionY,
  input  logic [7:0] BestDist,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_mx,
  output logic [3:0] res_my,
  output logic [7:0] res_dist,
  output logic       res_timeout
);

  localparam int RW = $clog2(RMEM_MAX);
  localparam int CW = $clog2(SMEM_MAX);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] R_LAST  = CW'(RMEM_MAX - 1);
  localparam logic [CW-1:0] S_LAST  = CW'(SMEM_MAX - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_R, LOAD_S, START, RUN, RESULT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WW-1:0]   watchdog;
  logic [7:0]      r_mem [RMEM_MAX];
  logic [7:0]      s_mem [SMEM_MAX];
  logic            wr_fire;

  assign wr_fire = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) begin
      if (state == LOAD_R) r_mem[cnt[RW-1:0]] <= wr_data;
      if (state == LOAD_S) s_mem[cnt] <= wr_data;
    end
  end

  // Read ports stay live in every state; the estimator only ever reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      R  <= 8'h00;
      S1 <= 8'h00;
      S2 <= 8'h00;
    end else begin
      R  <= r_mem[AddressR];
      S1 <= s_mem[AddressS1];
      S2 <= s_mem[AddressS2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      watchdog    <= '0;
      start       <= 1'b0;
      wr_ready    <= 1'b0;
      res_valid   <= 1'b0;
      res_mx      <= 4'h0;
      res_my      <= 4'h0;
      res_dist    <= 8'h00;
      res_timeout <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          wr_ready <= 1'b1;
          state    <= LOAD_R;
        end
        LOAD_R: begin
          if (wr_fire) begin
            if (cnt == R_LAST) begin
              cnt   <= '0;
              state <= LOAD_S;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        LOAD_S: begin
          if (wr_fire) begin
            if (cnt == S_LAST) begin
              cnt      <= '0;
              wr_ready <= 1'b0;
              start    <= 1'b1;
              state    <= START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        START: begin
          watchdog <= '0;
          state    <= RUN;
        end
        RUN: begin
          // A completion in the same cycle the watchdog expires still counts as success.
          watchdog <= watchdog + 1'b1;
          if (completed) begin
            res_mx      <= motionX;
            res_my      <= motionY;
            res_dist    <= BestDist;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= RESULT;
          end else if (watchdog == WD_LAST) begin
            res_mx      <= 4'h0;
            res_my      <= 4'h0;
            res_dist    <= 8'hFF;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cnt       <= '0;
            wr_ready  <= 1'b1;
            state     <= LOAD_R;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_frame_loader.sv
// Self-checking bench for me_frame_loader: a byte/cycle-count model checked every
// cycle, plus hand-computed expectations for loads, reads, results and aborts.
module tb_me_frame_loader;

  localparam int TO = 15;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       start;
  logic [7:0] AddressR;
  logic [9:0] AddressS1;
  logic [9:0] AddressS2;
  logic [7:0] R, S1, S2;
  logic       completed;
  logic [3:0] motionX, motionY;
  logic [7:0] BestDist;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_mx, res_my;
  logic [7:0] res_dist;
  logic       res_timeout;

  int checks = 0;
  int errors = 0;

  me_frame_loader #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start),
    .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
    .R(R), .S1(S1), .S2(S2),
    .completed(completed), .motionX(motionX), .motionY(motionY), .BestDist(BestDist),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_mx(res_mx), .res_my(res_my), .res_dist(res_dist), .res_timeout(res_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] patByte(input int pat, input int j);
    int t;
    case (pat)
      2:       t = j * 7 + 3;
      3:       t = ~j;
      default: t = j;
    endcase
    return t[7:0];
  endfunction

  // Model: a frame is 1280 accepted bytes (256 to R, rest to S), then a start
  // cycle, then up to TO run cycles, then a held result until res_ready.
  logic [7:0] ref_r [256];
  logic [7:0] ref_s [1024];
  bit   armed, boot, mem_known, read_known, running, nxt_start;
  int   nbytes, run_len;
  logic exp_wr_ready, exp_start, exp_res_valid, exp_res_timeout;
  logic [3:0] exp_mx, exp_my;
  logic [7:0] exp_dist, exp_R, exp_S1, exp_S2;

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("wr_ready", wr_ready, exp_wr_ready);
      checkOutput("start", start, exp_start);
      checkOutput("res_valid", res_valid, exp_res_valid);
      checkOutput("res_timeout", res_timeout, exp_res_timeout);
      checkOutput("res_mx", res_mx, exp_mx);
      checkOutput("res_my", res_my, exp_my);
      checkOutput("res_dist", res_dist, exp_dist);
      if (read_known) begin
        checkOutput("R", R, exp_R);
        checkOutput("S1", S1, exp_S1);
        checkOutput("S2", S2, exp_S2);
      end
    end
    if (!rst_n) begin
      armed = 1; boot = 1; mem_known = 0; running = 0; nbytes = 0; run_len = 0;
      exp_wr_ready = 0; exp_start = 0; exp_res_valid = 0; exp_res_timeout = 0;
      exp_mx = 0; exp_my = 0; exp_dist = 0;
      exp_R = 0; exp_S1 = 0; exp_S2 = 0; read_known = 1;
    end else if (armed) begin
      read_known = mem_known;
      exp_R  = ref_r[AddressR];
      exp_S1 = ref_s[AddressS1];
      exp_S2 = ref_s[AddressS2];
      nxt_start = 0;
      if (boot) begin
        boot = 0; exp_wr_ready = 1; nbytes = 0;
      end else if (exp_wr_ready) begin
        if (wr_valid) begin
          if (nbytes < 256) ref_r[nbytes] = wr_data;
          else ref_s[nbytes-256] = wr_data;
          nbytes++;
          if (nbytes == 1280) begin
            exp_wr_ready = 0; nxt_start = 1; mem_known = 1;
          end
        end
      end else if (exp_start) begin
        running = 1; run_len = 0;
      end else if (running) begin
        run_len++;
        if (completed) begin
          exp_mx = motionX; exp_my = motionY; exp_dist = BestDist;
          exp_res_timeout = 0; exp_res_valid = 1; running = 0;
        end else if (run_len == TO) begin
          exp_mx = 0; exp_my = 0; exp_dist = 8'hFF;
          exp_res_timeout = 1; exp_res_valid = 1; running = 0;
        end
      end else if (exp_res_valid && res_ready) begin
        exp_res_valid = 0; exp_wr_ready = 1; nbytes = 0;
      end
      exp_start = nxt_start;
    end
  end

  int wr_ready_cycles = 0;
  int accepted = 0;
  int start_count = 0;

  always @(negedge clk) begin
    if (wr_ready) wr_ready_cycles++;
    if (wr_valid && wr_ready) accepted++;
    if (start) start_count++;
  end

  // Drives one frame in order; optional idle gaps (with ignored completed/res_ready)
  // and an optional one-cycle reset once abort_at bytes have been accepted.
  task automatic applyStimulus(input int pat, input bit gaps, input int abort_at);
    int k = 0;
    int iter = 0;
    while (k < 1280) begin
      @(posedge clk); #1;
      if (k == abort_at) begin
        rst_n = 1'b0; wr_valid = 1'b0;
        return;
      end
      if (iter++ > 5000) begin
        errors++;
        $display("[TB] FAIL load_budget: accepted %0d bytes, required 1280", k);
        wr_valid = 1'b0;
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0; completed = 1'b1; res_ready = 1'b1;
      end else begin
        completed = 1'b0; res_ready = 1'b0;
        wr_valid = 1'b1; wr_data = patByte(pat, k);
        if (wr_ready) k++;
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; completed = 1'b0; res_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n, s0, a, b;
    rst_n = 0; wr_valid = 0; wr_data = 0; completed = 0; res_ready = 0;
    motionX = 0; motionY = 0; BestDist = 0;
    AddressR = 8'h05; AddressS1 = 10'h101; AddressS2 = 10'h3FF;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("reset_wr_ready", wr_ready, 0);
    checkOutput("reset_res_dist", res_dist, 0);
    checkOutput("reset_R", R, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Frame 1: no stalls, completion with held res_ready.
    applyStimulus(1, 0, -1);
    @(negedge clk); #1;
    checkOutput("start_after_last_byte", start, 1);
    @(posedge clk); #1;
    completed = 1; motionX = 4'h3; motionY = 4'hC; BestDist = 8'h2A;
    @(negedge clk); #1;
    checkOutput("run_read_R", R, 8'h05);
    checkOutput("run_read_S1", S1, 8'h01);
    checkOutput("run_read_S2", S2, 8'hFF);
    @(posedge clk); #1;
    completed = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checkOutput("hold_res_valid", res_valid, 1);
      checkOutput("hold_res_mx", res_mx, 4'h3);
      checkOutput("hold_res_my", res_my, 4'hC);
      checkOutput("hold_res_dist", res_dist, 8'h2A);
      checkOutput("hold_res_timeout", res_timeout, 0);
    end
    checkOutput("accepted_bytes", accepted[15:0], 16'd1280);
    checkOutput("wr_ready_cycles", wr_ready_cycles[15:0], 16'd1280);
    checkOutput("start_pulses", start_count[15:0], 16'd1);
    @(posedge clk); #1;
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    @(negedge clk); #1;
    checkOutput("res_valid_drop", res_valid, 0);
    checkOutput("reload_wr_ready", wr_ready, 1);

    // Frame 2: random gaps, watchdog expiry, readback in RUN and RESULT.
    applyStimulus(2, 1, -1);
    @(negedge clk); #1;
    checkOutput("start_after_gapped_load", start, 1);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      a = n * 17; b = n * 67;
      AddressR = a[7:0]; AddressS1 = b[9:0];
      b = (n % 2 == 1) ? b : n * 131;
      AddressS2 = b[9:0];
      @(negedge clk); #1;
      if (res_valid) break;
    end
    checkOutput("timeout_latency", n[15:0], 16'd16);
    checkOutput("timeout_flag", res_timeout, 1);
    checkOutput("timeout_dist", res_dist, 8'hFF);
    checkOutput("timeout_mx", res_mx, 0);
    @(posedge clk); #1;
    AddressR = 8'h10; AddressS1 = 10'h000; AddressS2 = 10'h001;
    @(posedge clk);
    @(negedge clk); #1;
    checkOutput("result_read_R", R, 8'h73);
    checkOutput("result_read_S1", S1, 8'h03);
    checkOutput("result_read_S2", S2, 8'h0A);
    @(posedge clk); #1;
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;

    // Frame 3: reset at byte 600, then a full reload finishing on the watchdog's last cycle.
    s0 = start_count;
    AddressR = 8'h05; AddressS1 = 10'h101; AddressS2 = 10'h3FF;
    applyStimulus(1, 0, 600);
    @(posedge clk);
    @(negedge clk); #1;
    checkOutput("abort_wr_ready", wr_ready, 0);
    checkOutput("abort_res_timeout", res_timeout, 0);
    checkOutput("abort_res_dist", res_dist, 0);
    checkOutput("abort_R", R, 0);
    checkOutput("abort_S2", S2, 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("abort_no_start", start_count[15:0], s0[15:0]);
    applyStimulus(3, 0, -1);
    @(negedge clk); #1;
    checkOutput("start_after_reload", start, 1);
    checkOutput("reload_start_count", start_count[15:0], 16'(s0 + 1));
    @(posedge clk); #1;
    @(negedge clk); #1;
    checkOutput("reload_read_R", R, 8'hFA);
    checkOutput("reload_read_S1", S1, 8'hFE);
    checkOutput("reload_read_S2", S2, 8'h00);
    repeat (14) begin @(posedge clk); #1; end
    completed = 1; motionX = 4'hA; motionY = 4'h5; BestDist = 8'h77;
    @(posedge clk); #1;
    completed = 0;
    @(negedge clk); #1;
    checkOutput("tie_res_valid", res_valid, 1);
    checkOutput("tie_res_timeout", res_timeout, 0);
    checkOutput("tie_res_mx", res_mx, 4'hA);
    checkOutput("tie_res_dist", res_dist, 8'h77);
    @(posedge clk); #1;
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    @(negedge clk); #1;
    checkOutput("tie_res_valid_drop", res_valid, 0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/me_frame_loader.md
ME_FRAME_LOADER -- requirements
Module: me_frame_loader

Interface
REQ-001 Parameter RMEM_MAX, default 256: reference-block byte count (16x16 pixels).
REQ-002 Parameter SMEM_MAX, default 1024: search-window byte count (32x32 pixels).
REQ-003 Parameter TIMEOUT, default 4095: max RUN cycles before abort.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 wr_valid  in  1  pixel byte available on wr_data.
REQ-008 wr_data  in  8  pixel byte; first RMEM_MAX bytes go to R store, next SMEM_MAX bytes go to S store.
REQ-009 wr_ready  out  1  loader accepts wr_data this cycle.
REQ-010 start  out  1  one-cycle pulse to the estimator.
REQ-011 AddressR  in  8  estimator read address into R store.
REQ-012 AddressS1  in  10  estimator read address 1 into S store.
REQ-013 AddressS2  in  10  estimator read address 2 into S store.
REQ-014 R, S1, S2  out  8 each  read data for AddressR, AddressS1, AddressS2.
REQ-015 completed  in  1  estimator done.
REQ-016 motionX, motionY  in  4 each  estimator motion vector.
REQ-017 BestDist  in  8  estimator best distortion.
REQ-018 res_valid  out  1  result registers hold a valid result.
REQ-019 res_ready  in  1  downstream accepts result.
REQ-020 res_mx, res_my  out  4 each; res_dist  out  8; res_timeout  out  1: captured result and abort flag.

Function
REQ-021 FSM states: IDLE, LOAD_R, LOAD_S, START, RUN, RESULT.
REQ-022 IDLE -> LOAD_R unconditionally next cycle; load counter cleared.
REQ-023 wr_ready SHALL be 1 only in LOAD_R and LOAD_S; a byte is written when wr_valid && wr_ready.
REQ-024 LOAD_R: byte k written to R store [k], k = 0..RMEM_MAX-1; after byte RMEM_MAX-1 -> LOAD_S, counter to 0.
REQ-025 LOAD_S: byte k written to S store [k]; after byte SMEM_MAX-1 -> START.
REQ-026 wr_valid low in a LOAD state: counter and state hold (stall allowed any length).
REQ-027 START: start = 1 for exactly one cycle, watchdog cleared, -> RUN.
REQ-028 RUN and START: R, S1, S2 SHALL be registered reads, 1-cycle latency: value on cycle n+1 = store[address sampled at edge n].
REQ-029 AddressS1 == AddressS2 SHALL return identical data on S1 and S2.
REQ-030 Outside START/RUN, R, S1, S2 SHALL continue registered reads (stores are read-only to the estimator).
REQ-031 RUN: watchdog increments each cycle; completed == 1 -> capture motionX, motionY, BestDist into res_mx/res_my/res_dist, res_timeout = 0, -> RESULT.
REQ-032 RUN: watchdog reaching TIMEOUT without completed -> res_mx = res_my = 0, res_dist = 8'hFF, res_timeout = 1, -> RESULT.
REQ-033 completed and watchdog == TIMEOUT in same cycle: completed wins, res_timeout = 0.
REQ-034 completed outside RUN SHALL be ignored.
REQ-035 RESULT: res_valid = 1, result registers stable until res_valid && res_ready; then -> LOAD_R, res_valid = 0 next cycle.
REQ-036 res_ready while res_valid == 0 SHALL be ignored.

Reset
REQ-037 rst_n == 0 at a rising edge: state = IDLE, counters and watchdog = 0, start = 0, wr_ready = 0, res_valid = 0, res_mx = res_my = 0, res_dist = 0, res_timeout = 0, R = S1 = S2 = 0.
REQ-038 Reset mid-load or mid-RUN SHALL abort without a start pulse or result; store contents are undefined after reset and SHALL be fully reloaded.

Verification
REQ-039 Load R[k] = k, S[k] = k[7:0] with no stalls -> wr_ready high for exactly 1280 accepted bytes, start pulses once on cycle after byte 1279.
REQ-040 In RUN drive AddressR = 8'h05, AddressS1 = 10'h101, AddressS2 = 10'h3FF -> next cycle R = 8'h05, S1 = 8'h01, S2 = 8'hFF.
REQ-041 completed with motionX = 4'h3, motionY = 4'hC, BestDist = 8'h2A, res_ready held low 10 cycles -> res_valid high, outputs stable 3/C/2A, res_timeout = 0 until res_ready.
REQ-042 Never assert completed, TIMEOUT = 15 -> RESULT after 15 RUN cycles with res_timeout = 1, res_dist = 8'hFF.
REQ-043 Random wr_valid gaps during load -> byte order preserved, readback matches pattern.
REQ-044 rst_n low for one cycle at byte 600 of load -> all outputs at reset values, no start; subsequent full load runs normally.
